// File: rtl/block_map_read_arbiter.sv
// rtl/block_map_read_arbiter.sv - round-robin arbiter serialising block_map RAM reads
// One outstanding read at a time; registered grant, data and valid go to the winner only.

module block_map_read_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 11,
    parameter int DATA_W = 2,
    parameter int RD_LAT = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]       rd_data,
    output logic [ADDR_W-1:0]       map_addr,
    input  logic [DATA_W-1:0]       map_data,
    output logic                    busy
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {
        ST_ARB,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [N_REQ-1:0]    vld_q, vld_d;
    logic [DATA_W-1:0]   data_q, data_d;

    logic                win_found;
    logic [PTR_W-1:0]    win_idx;
    logic [PTR_W-1:0]    cand;
    logic [ADDR_W-1:0]   win_addr;

    // Search starts just after the last winner, so the last winner has lowest priority.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = PTR_W'((int'(ptr_q) + k) % N_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        win_addr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == PTR_W'(i)) begin
                win_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        gnt_d   = '0;
        vld_d   = '0;
        data_d  = data_q;
        case (state_q)
            ST_ARB: begin
                if (win_found) begin
                    idx_d   = win_idx;
                    ptr_d   = win_idx;
                    addr_d  = win_addr;
                    gnt_d   = N_REQ'(1) << win_idx;
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(RD_LAT - 1)) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                data_d  = map_data;
                vld_d   = N_REQ'(1) << idx_q;
                state_d = ST_ARB;
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ARB;
            ptr_q   <= PTR_W'(N_REQ - 1);
            idx_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            gnt_q   <= '0;
            vld_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            gnt_q   <= gnt_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
        end
    end

    assign gnt      = gnt_q;
    assign rd_valid = vld_q;
    assign rd_data  = data_q;
    assign map_addr = addr_q;
    assign busy     = (state_q != ST_ARB);

endmodule

// File: tb/tb_block_map_read_arbiter.sv
// tb/tb_block_map_read_arbiter.sv - randomized bench for block_map_read_arbiter
// Transaction-level model predicts grant/valid cycles from the arbitration rules.

module tb_block_map_read_arbiter;

    localparam int N_REQ  = 4;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 2;
    localparam int RD_LAT = 1;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [N_REQ-1:0]        req;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        rd_valid;
    logic [DATA_W-1:0]       rd_data;
    logic [ADDR_W-1:0]       map_addr;
    logic [DATA_W-1:0]       map_data;
    logic                    busy;

    always #5 clk = ~clk;

    block_map_read_arbiter #(
        .N_REQ (N_REQ),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .req_addr(req_addr),
        .gnt     (gnt),
        .rd_valid(rd_valid),
        .rd_data (rd_data),
        .map_addr(map_addr),
        .map_data(map_data),
        .busy    (busy)
    );

    // block_map RAM with RD_LAT cycles from address to data
    logic [DATA_W-1:0] ram [1<<ADDR_W];
    logic [ADDR_W-1:0] pipe [RD_LAT];

    always @(posedge clk) begin
        pipe[0] <= map_addr;
        for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign map_data = ram[pipe[RD_LAT-1]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    endtask

    // model: a read granted at cycle t owns cycles t+1 .. t+1+RD_LAT, valid at t+2+RD_LAT
    int                next_arb = 0;
    int                gnt_cyc  = -1;
    int                val_cyc  = -1;
    int                m_ptr    = N_REQ - 1;
    int                m_idx    = 0;
    int                j;
    logic [ADDR_W-1:0] pend_addr = '0;
    logic [ADDR_W-1:0] cur_addr  = '0;
    logic [DATA_W-1:0] pend_data = '0;
    logic [DATA_W-1:0] cur_data  = '0;
    logic [N_REQ-1:0]  exp_gnt, exp_val;

    always @(negedge clk) begin
        if (cyc >= 1) begin
            exp_gnt = (cyc == gnt_cyc) ? (N_REQ'(1) << m_idx) : '0;
            exp_val = (cyc == val_cyc) ? (N_REQ'(1) << m_idx) : '0;
            if (cyc == gnt_cyc) cur_addr = pend_addr;
            if (cyc == val_cyc) cur_data = pend_data;
            check("gnt",      32'(gnt),      32'(exp_gnt));
            check("rd_valid", 32'(rd_valid), 32'(exp_val));
            check("rd_data",  32'(rd_data),  32'(cur_data));
            check("map_addr", 32'(map_addr), 32'(cur_addr));
            check("busy",     32'(busy),     32'(cyc < next_arb));
        end
        if (reset) begin
            next_arb = cyc + 1;
            gnt_cyc  = -1;
            val_cyc  = -1;
            m_ptr    = N_REQ - 1;
            cur_addr = '0;
            cur_data = '0;
        end else if (cyc >= next_arb && req != '0) begin
            for (int k = 1; k <= N_REQ; k++) begin
                j = (m_ptr + k) % N_REQ;
                if (req[j]) begin
                    m_idx = j;
                    break;
                end
            end
            m_ptr     = m_idx;
            pend_addr = req_addr[m_idx*ADDR_W +: ADDR_W];
            pend_data = ram[pend_addr];
            gnt_cyc   = cyc + 1;
            val_cyc   = cyc + 2 + RD_LAT;
            next_arb  = val_cyc;
        end
    end

    // percentages: drop on own grant, raise when idle, forget while pending
    task automatic step(input int p_drop, input int p_raise, input int p_forget);
        @(posedge clk);
        #1;
        for (int i = 0; i < N_REQ; i++) begin
            if (req[i] && gnt[i]) begin
                if (int'($urandom_range(99)) < p_drop) req[i] = 1'b0;
            end else if (!req[i]) begin
                req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
                if (int'($urandom_range(99)) < p_raise) req[i] = 1'b1;
            end else if (int'($urandom_range(99)) < p_forget) begin
                req[i] = 1'b0;
            end
        end
    endtask

    initial begin
        for (int a = 0; a < (1 << ADDR_W); a++) ram[a] = DATA_W'($urandom);
        ram[70]  = 2'b10;
        reset    = 1'b1;
        req      = '0;
        req_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        req_addr[2*ADDR_W +: ADDR_W] = 11'd70;
        req = 4'b0100;
        repeat (8) step(100, 0, 0);

        for (int i = 0; i < N_REQ; i++) req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
        req = 4'b1111;
        repeat (16) step(100, 0, 0);

        req = 4'b0101;
        repeat (15) step(0, 0, 0);
        req = '0;
        repeat (5) step(100, 0, 0);

        req = 4'b0010;
        step(100, 0, 0);
        step(100, 0, 0);
        reset = 1'b1;
        step(100, 0, 0);
        reset = 1'b0;
        req = 4'b1000;
        repeat (6) step(100, 0, 0);

        req = 4'b0001;
        step(100, 0, 0);
        step(100, 0, 0);
        req[1] = 1'b1;
        step(100, 0, 100);
        repeat (5) step(100, 0, 0);

        repeat (3000) begin
            step(75, 30, 3);
            reset = ($urandom_range(149) == 0);
        end
        reset = 1'b0;
        req   = '0;
        repeat (6) step(100, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
